// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key/word types, round count,
// GF(2^8) xtime helper and the key-schedule controller state type.
package aes_pkg;

  typedef logic [127:0] aes_key_t;
  typedef logic [31:0]  aes_word_t;

  localparam int unsigned AES128_ROUNDS = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_STORE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } aes_ks_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_schedule_ctrl_if.sv
// Bus between the key-schedule controller and the G-function/XOR round-key unit.
//  unit_en_o   : controller -> unit, request active
//  unit_word_o : controller -> unit, w3 of the previous round key
//  unit_key_o  : controller -> unit, previous round key
//  unit_rcon_o : controller -> unit, round constant
//  unit_done_i : unit -> controller, result valid pulse
//  unit_key_i  : unit -> controller, new round key
interface aes_key_schedule_ctrl_if;
  import aes_pkg::*;

  logic       unit_en_o;
  aes_word_t  unit_word_o;
  aes_key_t   unit_key_o;
  logic [7:0] unit_rcon_o;
  logic       unit_done_i;
  aes_key_t   unit_key_i;

  modport master (
    output unit_en_o, unit_word_o, unit_key_o, unit_rcon_o,
    input  unit_done_i, unit_key_i
  );

  modport slave (
    input  unit_en_o, unit_word_o, unit_key_o, unit_rcon_o,
    output unit_done_i, unit_key_i
  );
endinterface

// File: rtl/aes_roundkey_rf.sv
// Round-key register file: NUM_KEYS x 128 bits.
//  clk_i/rst_i : clock, synchronous active-high clear of all entries
//  we_i, waddr_i, wdata_i : synchronous write port
//  raddr_i, rdata_o       : asynchronous read port, '0 for out-of-range index
module aes_roundkey_rf
  import aes_pkg::*;
#(
  parameter int unsigned NUM_KEYS = AES128_ROUNDS + 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       we_i,
  input  logic [3:0] waddr_i,
  input  aes_key_t   wdata_i,
  input  logic [3:0] raddr_i,
  output aes_key_t   rdata_o
);

  aes_key_t mem [NUM_KEYS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem <= '{default: '0};
    end else if (we_i && (32'(waddr_i) < NUM_KEYS)) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (32'(raddr_i) < NUM_KEYS) begin
      rdata_o = mem[raddr_i];
    end
  end

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key-expansion sequencer. Latches the cipher key, drives the
// round-key unit one round at a time with the round constant, stores all
// NUM_ROUNDS+1 round keys and serves them on an asynchronous read port.
//  clk_i, rst_i       : clock, synchronous active-high reset
//  start_i, key_i     : expansion request (accepted in IDLE only) and key
//  busy_o, done_o     : expansion in progress / 1-cycle completion pulse
//  err_o              : sticky unit timeout flag, cleared by next accepted start
//  rd_idx_i, rd_key_o : round-key read port ('0 beyond NUM_ROUNDS)
//  unit               : request/response bus to the round-key unit
module aes_key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS  = AES128_ROUNDS,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  aes_key_t   key_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  input  logic [3:0] rd_idx_i,
  output aes_key_t   rd_key_o,
  aes_key_schedule_ctrl_if.master unit
);

  localparam int unsigned CTR_W = $clog2(TIMEOUT_CYC + 1);

  aes_ks_state_e    state_q;
  logic [3:0]       round_q;
  logic [7:0]       rcon_q;
  logic [CTR_W-1:0] ctr_q;
  logic             err_q;
  // Holds the previous round key: the cipher key after acceptance, then each
  // unit result. It doubles as the store holding register and as the unit
  // operand source, so the register file needs only the external read port.
  aes_key_t         prev_q;

  logic             rf_we;
  logic [3:0]       rf_waddr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      round_q <= 4'd1;
      rcon_q  <= 8'h01;
      ctr_q   <= '0;
      err_q   <= 1'b0;
      prev_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            prev_q  <= key_i;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          err_q   <= 1'b0;
          round_q <= 4'd1;
          rcon_q  <= 8'h01;
          state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          ctr_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          ctr_q <= ctr_q + CTR_W'(1);
          // A response in the expiry cycle still counts.
          if (unit.unit_done_i) begin
            prev_q  <= unit.unit_key_i;
            state_q <= ST_STORE;
          end else if (ctr_q == CTR_W'(TIMEOUT_CYC - 1)) begin
            state_q <= ST_ERR;
          end
        end
        ST_STORE: begin
          rcon_q <= xtime(rcon_q);
          if (round_q == 4'(NUM_ROUNDS)) begin
            state_q <= ST_DONE;
          end else begin
            round_q <= round_q + 4'd1;
            state_q <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        ST_ERR: begin
          err_q   <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rf_we    = (state_q == ST_LOAD) || (state_q == ST_STORE);
    rf_waddr = (state_q == ST_LOAD) ? 4'd0 : round_q;
  end

  aes_roundkey_rf #(
    .NUM_KEYS(NUM_ROUNDS + 1)
  ) u_rf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (rf_we),
    .waddr_i (rf_waddr),
    .wdata_i (prev_q),
    .raddr_i (rd_idx_i),
    .rdata_o (rd_key_o)
  );

  assign busy_o           = (state_q != ST_IDLE);
  assign done_o           = (state_q == ST_DONE);
  assign err_o            = err_q;
  assign unit.unit_en_o   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign unit.unit_key_o  = prev_q;
  assign unit.unit_word_o = prev_q[31:0];
  assign unit.unit_rcon_o = rcon_q;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
module tb_aes_key_schedule_ctrl;
  import aes_pkg::*;

  localparam int unsigned NR    = 10;
  localparam int unsigned TO    = 64;
  localparam int unsigned NEVER = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s;
  aes_key_t   key;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] rd_idx;
  aes_key_t   rd_key;

  aes_key_schedule_ctrl_if u_if ();

  aes_key_schedule_ctrl #(
    .NUM_ROUNDS  (NR),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start_s),
    .key_i    (key),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err),
    .rd_idx_i (rd_idx),
    .rd_key_o (rd_key),
    .unit     (u_if)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0]  exp_rcon [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  aes_key_t    exp_rk   [0:10];
  aes_key_t    model_rf [0:15];
  int unsigned lat_tab  [1:10];
  int unsigned issue_no = 0;
  int unsigned en_cnt   = 0;
  int unsigned ci       = 0;
  int unsigned done_cnt = 0;
  logic        en_prev  = 1'b0;
  logic        done_prev = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- behavioural AES key-expansion model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse (x^254) then affine map.
  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    logic [7:0] sq, inv, s;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    s = inv;
    for (int i = 1; i <= 4; i++) s = s ^ ((inv << i) | (inv >> (8 - i)));
    return s ^ 8'h63;
  endfunction

  function automatic aes_key_t next_key(input aes_key_t p, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {p[23:0], p[31:24]};
    t  = {sub_byte(t[31:24]), sub_byte(t[23:16]), sub_byte(t[15:8]), sub_byte(t[7:0])}
         ^ {rc, 24'h000000};
    n0 = p[127:96] ^ t;
    n1 = p[95:64]  ^ n0;
    n2 = p[63:32]  ^ n1;
    n3 = p[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  task automatic model_expand(input aes_key_t k);
    exp_rk[0] = k;
    for (int r = 1; r <= 10; r++) exp_rk[r] = next_key(exp_rk[r-1], exp_rcon[r]);
  endtask

  // ---------------- round-key unit model (configurable latency) ----------------
  // Responds in WAIT cycle lat_tab[round]; values above TO never arrive in time.
  always @(negedge clk) begin
    if (u_if.unit_en_o) begin
      if (en_cnt == 0) issue_no++;
      en_cnt++;
      if (issue_no >= 1 && issue_no <= NR && en_cnt == lat_tab[issue_no] + 1) begin
        u_if.unit_done_i = 1'b1;
        u_if.unit_key_i  = next_key(u_if.unit_key_o, u_if.unit_rcon_o);
      end else begin
        u_if.unit_done_i = 1'b0;
        u_if.unit_key_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end else begin
      en_cnt           = 0;
      u_if.unit_done_i = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (u_if.unit_en_o) begin
        if (!en_prev) ci++;
        if (ci >= 1 && ci <= NR) begin
          chk("unit_rcon", 128'(u_if.unit_rcon_o), 128'(exp_rcon[ci]));
          chk("unit_key",  u_if.unit_key_o, exp_rk[ci-1]);
          chk("unit_word", 128'(u_if.unit_word_o), 128'(exp_rk[ci-1][31:0]));
        end else begin
          chk("unit_issue_count", 128'(ci), 128'(NR));
        end
        chk("busy_while_en", 128'(busy), 128'(1));
      end
      if (done) begin
        done_cnt++;
        chk("done_single_cycle", 128'(done_prev), 128'(0));
      end
    end
    en_prev   = u_if.unit_en_o;
    done_prev = done;
  end

  // ---------------- stimulus ----------------
  task automatic sweep_rd(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_idx = 4'(i);
      #1;
      chk($sformatf("%s[%0d]", tag, i), rd_key, model_rf[i]);
    end
  endtask

  task automatic start_run(input aes_key_t k, input bit hold);
    model_expand(k);
    issue_no = 0;
    ci       = 0;
    done_cnt = 0;
    @(negedge clk);
    key     = k;
    start_s = 1'b1;
    @(negedge clk);
    if (!hold) start_s = 1'b0;
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic finish_run();
    int unsigned fail_r, last;
    fail_r = 0;
    for (int r = 10; r >= 1; r--) if (lat_tab[r] > TO) fail_r = r;
    for (int c = 0; c < 3000 && busy; c++) @(negedge clk);
    start_s = 1'b0;
    chk("run_ends", 128'(busy), 128'(0));
    chk("done_count", 128'(done_cnt), (fail_r == 0) ? 128'(1) : 128'(0));
    chk("err_flag", 128'(err), 128'(fail_r != 0));
    last = (fail_r == 0) ? NR : fail_r - 1;
    for (int i = 0; i <= int'(last); i++) model_rf[i] = exp_rk[i];
    sweep_rd("rd_key");
  endtask

  task automatic rand_lat(input int unsigned lo, input int unsigned hi);
    for (int r = 1; r <= 10; r++) lat_tab[r] = $urandom_range(hi, lo);
  endtask

  function automatic aes_key_t rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    aes_key_t k;
    bit       found;

    rst = 1'b1; start_s = 1'b0; key = '0; rd_idx = '0;
    u_if.unit_done_i = 1'b0; u_if.unit_key_i = '0;
    for (int i = 0; i < 16; i++) model_rf[i] = '0;
    for (int r = 1; r <= 10; r++) lat_tab[r] = 3;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_unit_en", 128'(u_if.unit_en_o), 128'(0));
    chk("rst_rcon", 128'(u_if.unit_rcon_o), 128'(8'h01));
    rst = 1'b0;
    sweep_rd("rst_rd");

    // FIPS-197 appendix A.1 key, unit latency 3
    start_run(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    chk("model_rk10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    finish_run();
    @(negedge clk); rd_idx = 4'd10; #1;
    chk("fips_rk10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(negedge clk); rd_idx = 4'd1; #1;
    chk("fips_rk1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);

    // random keys and latencies
    for (int n = 0; n < 3; n++) begin
      rand_lat(1, 6);
      start_run(rand_key(), 1'b0);
      finish_run();
    end

    // start held high throughout with key_i changing: single expansion of the first key
    rand_lat(1, 4);
    start_run(rand_key(), 1'b1);
    finish_run();
    repeat (3) @(negedge clk);
    chk("no_requeue_busy", 128'(busy), 128'(0));
    chk("no_requeue_done", 128'(done_cnt), 128'(1));

    // unit silent in round 4: error, rk[0..3] new, rk[4..10] retain old values
    rand_lat(1, 4);
    lat_tab[4] = NEVER;
    start_run(rand_key(), 1'b0);
    finish_run();

    // recovery: next accepted start clears err_o
    rand_lat(1, 4);
    start_run(rand_key(), 1'b0);
    finish_run();

    // response exactly in the expiry cycle wins over the timeout
    rand_lat(1, 4);
    lat_tab[2] = TO;
    start_run(rand_key(), 1'b0);
    finish_run();

    // one cycle later is a timeout in round 1
    rand_lat(1, 4);
    lat_tab[1] = TO + 1;
    start_run(rand_key(), 1'b0);
    finish_run();

    // reset during round 5 WAIT aborts with no done_o and clears everything
    for (int r = 1; r <= 10; r++) lat_tab[r] = 5;
    k = rand_key();
    start_run(k, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      #1;
      found = (issue_no == 5);
    end
    chk("reached_round5", 128'(found), 128'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_done", 128'(done), 128'(0));
    chk("midrst_err", 128'(err), 128'(0));
    chk("midrst_unit_en", 128'(u_if.unit_en_o), 128'(0));
    chk("midrst_unit_key", u_if.unit_key_o, 128'(0));
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model_rf[i] = '0;
    repeat (4) @(negedge clk);
    chk("midrst_no_done", 128'(done_cnt), 128'(0));
    chk("midrst_idle", 128'(busy), 128'(0));
    sweep_rd("midrst_rd");

    // normal run after the abort
    rand_lat(1, 6);
    start_run(rand_key(), 1'b0);
    finish_run();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
